// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: FSM states, register offsets and CTRL bit positions for mmio_timer
package mmio_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_PRESC = 8;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits one tick every presc+1 cycles while run is high
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] presc_cnt;
    assign tick = run && presc_cnt == presc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_cnt <= '0;
        else if (clr) presc_cnt <= '0;
        else if (run) presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, auto-reload and level interrupt
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    state_t             state;
    logic               en, auto, ie, exp;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        load, count;
    logic               ctrl_wr, load_wr, tick, expire, start;
    assign ctrl_wr = we && addr == OFF_CTRL;
    assign load_wr = we && addr == OFF_LOAD;
    assign expire  = tick && count <= 32'd1;
    assign start   = ctrl_wr && wdata[CTRL_EN] && state != RUN;
    assign irq     = exp & ie;
    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .run   (state == RUN),
        .presc (presc),
        .tick  (tick)
    );
    always_comb begin
        rdata = addr == OFF_CTRL  ? (32'(presc) << CTRL_PRESC) | 32'({ie, auto, en}) :
                addr == OFF_LOAD  ? load :
                addr == OFF_COUNT ? count : {31'b0, exp};
    end
    // CTRL writes take priority over tick-driven changes; expiry always sets EXP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            en    <= 1'b0;
            auto  <= 1'b0;
            ie    <= 1'b0;
            presc <= '0;
            load  <= '0;
            count <= '0;
            exp   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                auto  <= wdata[CTRL_AUTO];
                ie    <= wdata[CTRL_IE];
                presc <= wdata[CTRL_PRESC +: PRESC_W];
            end
            if (load_wr) load <= wdata;
            if (we && addr == OFF_STATUS && wdata[0]) exp <= 1'b0;
            if (expire) exp <= 1'b1;
            if (ctrl_wr && !wdata[CTRL_EN]) begin
                state <= IDLE;
                en    <= 1'b0;
            end else if (start) begin
                state <= RUN;
                en    <= 1'b1;
                count <= load;
            end else if (tick) begin
                if (count > 32'd1) count <= count - 32'd1;
                else if (auto) count <= load_wr ? wdata : load;
                else begin
                    count <= '0;
                    en    <= 1'b0;
                    state <= EXPIRED;
                end
            end
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: table vectors, directed corner sequences and randomized run against a behavioural model
module tb_mmio_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    int checks = 0;
    int errors = 0;

    mmio_timer #(.PRESC_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] rd;
        logic        irq;
    } vec_t;
    vec_t vt[9];

    // model: timer is either counting or not; elapsed-cycle count drives ticks
    logic        m_run, m_en, m_auto, m_ie, m_exp;
    int          m_presc, m_e;
    logic [31:0] m_load, m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        we = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        {m_run, m_en, m_auto, m_ie, m_exp} = '0;
        m_presc = 0; m_e = 0; m_load = 0; m_count = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] a, input logic [31:0] v);
        addr = a;
        #1 check(name, rdata, v);
    endtask

    task automatic model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
        logic tick, expire, n_run, n_en;
        logic [31:0] n_count;
        tick = m_run && m_e == m_presc;
        expire = tick && m_count <= 1;
        n_run = m_run; n_en = m_en; n_count = m_count;
        if (tick) m_e = 0;
        else if (m_run) m_e = (m_e + 1) % 256;
        if (tick) begin
            if (m_count > 1) n_count = m_count - 1;
            else if (m_auto) n_count = (w && a == 2'd1) ? d : m_load;
            else begin n_count = 0; n_run = 0; n_en = 0; end
        end
        if (w && a == 2'd0) begin
            if (!d[0]) begin n_run = 0; n_en = 0; n_count = m_count; end
            else if (!m_run) begin n_run = 1; n_en = 1; n_count = m_load; m_e = 0; end
            m_auto = d[1]; m_ie = d[2]; m_presc = int'(d[15:8]);
        end
        if (w && a == 2'd1) m_load = d;
        if (w && a == 2'd3 && d[0]) m_exp = 0;
        if (expire) m_exp = 1;
        m_count = n_count; m_run = n_run; m_en = n_en;
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0: return (32'(m_presc) << 8) | {29'd0, m_ie, m_auto, m_en};
            2'd1: return m_load;
            2'd2: return m_count;
            default: return {31'd0, m_exp};
        endcase
    endfunction

    initial begin
        vt[0] = '{1'b0, 2'd0, 32'd0,          2'd0, 32'd0,          1'b0};
        vt[1] = '{1'b0, 2'd0, 32'd0,          2'd1, 32'd0,          1'b0};
        vt[2] = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd0,          1'b0};
        vt[3] = '{1'b0, 2'd0, 32'd0,          2'd3, 32'd0,          1'b0};
        vt[4] = '{1'b1, 2'd1, 32'h12345678,   2'd1, 32'h12345678,   1'b0};
        vt[5] = '{1'b1, 2'd0, 32'hFFFF_FFF6,  2'd0, 32'h0000_FF06,  1'b0};
        vt[6] = '{1'b1, 2'd2, 32'h0000_FFFF,  2'd2, 32'd0,          1'b0};
        vt[7] = '{1'b1, 2'd3, 32'hFFFF_FFFF,  2'd3, 32'd0,          1'b0};
        vt[8] = '{1'b1, 2'd0, 32'd0,          2'd0, 32'd0,          1'b0};

        do_reset();
        foreach (vt[i]) begin
            addr = vt[i].addr; wdata = vt[i].wdata; we = vt[i].we;
            @(posedge clk);
            #1 we = 1'b0;
            addr = vt[i].raddr;
            #1 check($sformatf("vec%0d_rdata", i), rdata, vt[i].rd);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].irq});
        end

        // one-shot, LOAD=5, PRESC=0, IE=1
        do_reset();
        wr(2'd1, 5); wr(2'd0, 32'h5);
        cycles(4); chk("oneshot_exp_early", 2'd3, 0);
        cycles(1); chk("oneshot_exp", 2'd3, 1);
        check("oneshot_irq", {31'd0, irq}, 1);
        chk("oneshot_count", 2'd2, 0);
        chk("oneshot_ctrl", 2'd0, 32'h4);

        // prescale + auto-reload
        do_reset();
        wr(2'd1, 3); wr(2'd0, 32'h303);
        cycles(11); chk("auto_exp_early", 2'd3, 0); chk("auto_count_early", 2'd2, 1);
        cycles(1); chk("auto_exp", 2'd3, 1); chk("auto_count", 2'd2, 3);
        chk("auto_ctrl_run", 2'd0, 32'h303);

        // W1C coincident with expiry, then clear
        do_reset();
        wr(2'd1, 2); wr(2'd0, 32'h5);
        cycles(1); wr(2'd3, 1);
        chk("w1c_coincident", 2'd3, 1);
        wr(2'd3, 1);
        chk("w1c_clear", 2'd3, 0);
        check("w1c_irq", {31'd0, irq}, 0);

        // disable mid-count
        do_reset();
        wr(2'd1, 10); wr(2'd0, 32'h1);
        cycles(4); wr(2'd0, 32'h0);
        chk("dis_count", 2'd2, 6);
        cycles(5); chk("dis_count_hold", 2'd2, 6);
        chk("dis_exp", 2'd3, 0); chk("dis_ctrl", 2'd0, 0);

        // async reset mid-RUN
        do_reset();
        wr(2'd1, 10); wr(2'd0, 32'h5);
        cycles(3); chk("rst_pre_count", 2'd2, 7);
        rst_n = 1'b0;
        chk("rst_ctrl", 2'd0, 0); chk("rst_load", 2'd1, 0); chk("rst_count", 2'd2, 0);
        check("rst_irq", {31'd0, irq}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(3); chk("rst_idle_count", 2'd2, 0); chk("rst_idle_ctrl", 2'd0, 0);

        // LOAD=0 acts as 1; COUNT is read-only
        do_reset();
        wr(2'd0, 32'h201);
        cycles(2); chk("load0_exp_early", 2'd3, 0);
        cycles(1); chk("load0_exp", 2'd3, 1); chk("load0_ctrl", 2'd0, 32'h200);
        wr(2'd2, 32'hFFFF); chk("count_ro", 2'd2, 0);

        // auto-reload coincident with LOAD write
        do_reset();
        wr(2'd1, 2); wr(2'd0, 32'h3);
        cycles(1); wr(2'd1, 9);
        chk("reload_newload", 2'd2, 9); chk("reload_exp", 2'd3, 1);

        // disable coincident with expiry
        do_reset();
        wr(2'd1, 1); wr(2'd0, 32'h1);
        wr(2'd0, 32'h0);
        chk("disexp_exp", 2'd3, 1); chk("disexp_ctrl", 2'd0, 0); chk("disexp_count", 2'd2, 1);

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            we = ($urandom % 3) == 0;
            addr = 2'($urandom);
            case (addr)
                2'd0: wdata = {$urandom, 8'h0} & 32'h0000_FF00 & {22'd0, 2'($urandom), 8'hFF} | 32'($urandom % 8);
                2'd1: wdata = 32'($urandom % 7);
                default: wdata = $urandom;
            endcase
            model_step(we, addr, wdata);
            @(posedge clk);
            #1 we = 1'b0;
            addr = 2'($urandom);
            #1 check("rand_rdata", rdata, model_rd(addr));
            check("rand_irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
